// File: rtl/cmd_reg_bank_if.sv
// Command bus interface: one request per cycle while sel is high and a registered ack
// one cycle later. rd_wr_n=1 requests a read, rd_wr_n=0 requests a write.
interface intf_cmd #(
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned ADDR_BITS = 32
) ();
    logic                 sel;
    logic                 rd_wr_n;
    logic [ADDR_BITS-1:0] byte_addr;
    logic [DATA_BITS-1:0] wdata;
    logic [DATA_BITS-1:0] rdata;
    logic                 ack;

    modport master (
        output sel,
        output rd_wr_n,
        output byte_addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  sel,
        input  rd_wr_n,
        input  byte_addr,
        input  wdata,
        output rdata,
        output ack
    );
endinterface

// File: rtl/cmd_reg_bank.sv
// Generic command-bus register bank.
// NUM_REGS registers of DATA_BITS each, decoded from BASE_ADDR at DATA_BITS/8 stride.
// Each register is RW, RO (driven by i_hw_val) or W1C (sticky, set by i_hw_set).
// Every sampled sel cycle is one transaction, answered with a one-cycle ack the next
// cycle, including accesses that miss the register window.
// Optional build macro CMD_REG_BANK_ERR_EN adds o_bad_addr / o_bad_addr_cnt and makes
// miss reads return 0xDEADBEEF instead of 0.
module cmd_reg_bank #(
    parameter int unsigned                   DATA_BITS = 32,
    parameter int unsigned                   NUM_REGS  = 8,
    parameter int unsigned                   ADDR_BITS = 32,
    parameter int unsigned                   BASE_ADDR = 0,
    parameter logic [NUM_REGS-1:0]           RO_MASK   = '0,
    parameter logic [NUM_REGS-1:0]           W1C_MASK  = '0,
    parameter logic [NUM_REGS*DATA_BITS-1:0] RST_VALS  = '0
) (
    input  logic                          i_sysclk,
    input  logic                          i_srst_n,
    intf_cmd.slave                        cmd,
    input  logic [NUM_REGS*DATA_BITS-1:0] i_hw_val,
    input  logic [NUM_REGS*DATA_BITS-1:0] i_hw_set,
    output logic [NUM_REGS*DATA_BITS-1:0] o_regs,
    output logic [NUM_REGS-1:0]           o_wr_stb,
    output logic [NUM_REGS-1:0]           o_rd_stb
`ifdef CMD_REG_BANK_ERR_EN
    ,
    output logic                          o_bad_addr,
    output logic [15:0]                   o_bad_addr_cnt
`endif
);

    // Guard the divisor so a bad DATA_BITS still elaborates far enough to report it.
    localparam int unsigned          BytesRaw = DATA_BITS / 8;
    localparam int unsigned          Bytes    = (BytesRaw == 0) ? 1 : BytesRaw;
    localparam logic [ADDR_BITS-1:0] BaseA    = ADDR_BITS'(BASE_ADDR);
    localparam logic [ADDR_BITS-1:0] BytesA   = ADDR_BITS'(Bytes);
    localparam logic [ADDR_BITS-1:0] NumA     = ADDR_BITS'(NUM_REGS);

`ifdef CMD_REG_BANK_ERR_EN
    localparam logic [DATA_BITS-1:0] MissVal = DATA_BITS'(64'hDEAD_BEEF);
`else
    localparam logic [DATA_BITS-1:0] MissVal = '0;
`endif

    // ------------------------------------------------------------------
    // Elaboration-time configuration checks
    // ------------------------------------------------------------------
    if ((DATA_BITS == 0) || ((DATA_BITS % 8) != 0)) begin : g_err_data_bits
        $error("cmd_reg_bank: DATA_BITS must be a non-zero multiple of 8");
    end

    if ((BASE_ADDR % Bytes) != 0) begin : g_err_base_align
        $error("cmd_reg_bank: BASE_ADDR must be aligned to DATA_BITS/8");
    end

    if ((RO_MASK & W1C_MASK) != '0) begin : g_err_mask_overlap
        $error("cmd_reg_bank: RO_MASK and W1C_MASK overlap");
    end

    if ((NUM_REGS < 1) || (NUM_REGS > 256)) begin : g_err_num_regs
        $error("cmd_reg_bank: NUM_REGS must be in 1..256");
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [ADDR_BITS:0]   w_diff;
    logic [ADDR_BITS-1:0] w_off;
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_below_base;
    logic                 w_hit;
    logic [NUM_REGS-1:0]  w_dec;
    logic                 w_wr_req;
    logic                 w_rd_req;

    // Decode byte_addr into a one-hot register select; the extra top bit of the
    // subtraction is the borrow, i.e. byte_addr below BASE_ADDR.
    always_comb begin
        w_diff       = {1'b0, cmd.byte_addr} - {1'b0, BaseA};
        w_below_base = w_diff[ADDR_BITS];
        w_off        = w_diff[ADDR_BITS-1:0];
        w_idx        = w_off / BytesA;
        w_hit        = !w_below_base && ((w_off % BytesA) == '0) && (w_idx < NumA);
        w_dec        = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_dec[i] = w_hit && (w_idx == ADDR_BITS'(i));
        end
    end

    assign w_wr_req = cmd.sel && !cmd.rd_wr_n;
    assign w_rd_req = cmd.sel && cmd.rd_wr_n;

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] w_rd_val [NUM_REGS];

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (RO_MASK[gi]) begin : g_ro
            // No storage: reads see the live hardware value, o_regs slice is tied off.
            assign w_rd_val[gi]                          = i_hw_val[gi*DATA_BITS +: DATA_BITS];
            assign o_regs[gi*DATA_BITS +: DATA_BITS]     = '0;
        end else if (W1C_MASK[gi]) begin : g_w1c
            localparam logic [DATA_BITS-1:0] RstVal = RST_VALS[gi*DATA_BITS +: DATA_BITS];
            logic [DATA_BITS-1:0] r_val;
            logic [DATA_BITS-1:0] w_clr;
            logic [DATA_BITS-1:0] w_set;

            assign w_clr = (w_wr_req && w_dec[gi]) ? cmd.wdata : '0;
            assign w_set = i_hw_set[gi*DATA_BITS +: DATA_BITS];

            // Sticky update every cycle; a hardware set wins over a same-cycle clear.
            always_ff @(posedge i_sysclk) begin
                if (!i_srst_n) begin
                    r_val <= RstVal;
                end else begin
                    r_val <= (r_val & ~w_clr) | w_set;
                end
            end

            assign w_rd_val[gi]                      = r_val;
            assign o_regs[gi*DATA_BITS +: DATA_BITS] = r_val;
        end else begin : g_rw
            localparam logic [DATA_BITS-1:0] RstVal = RST_VALS[gi*DATA_BITS +: DATA_BITS];
            logic [DATA_BITS-1:0] r_val;

            // Plain storage, loaded on a hit write.
            always_ff @(posedge i_sysclk) begin
                if (!i_srst_n) begin
                    r_val <= RstVal;
                end else if (w_wr_req && w_dec[gi]) begin
                    r_val <= cmd.wdata;
                end
            end

            assign w_rd_val[gi]                      = r_val;
            assign o_regs[gi*DATA_BITS +: DATA_BITS] = r_val;
        end
    end

    // Slices of i_hw_val / i_hw_set belonging to other register kinds are don't-care.
    logic w_unused_hw;
    assign w_unused_hw = ^{i_hw_val, i_hw_set};

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] w_hit_val;

    // OR-reduce the selected register value; w_dec is one-hot or zero.
    always_comb begin
        w_hit_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_dec[i]) begin
                w_hit_val = w_hit_val | w_rd_val[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    logic                 r_ack;
    logic [DATA_BITS-1:0] r_rdata;
    logic [NUM_REGS-1:0]  r_wr_stb;
    logic [NUM_REGS-1:0]  r_rd_stb;

    // ack, read data and strobes all land one cycle after the sampled sel; rdata holds
    // its value between reads.
    always_ff @(posedge i_sysclk) begin
        if (!i_srst_n) begin
            r_ack    <= 1'b0;
            r_rdata  <= '0;
            r_wr_stb <= '0;
            r_rd_stb <= '0;
        end else begin
            r_ack    <= cmd.sel;
            r_wr_stb <= w_wr_req ? (w_dec & ~RO_MASK) : '0;
            r_rd_stb <= w_rd_req ? w_dec : '0;
            if (w_rd_req) begin
                r_rdata <= w_hit ? w_hit_val : MissVal;
            end
        end
    end

    assign cmd.ack   = r_ack;
    assign cmd.rdata = r_rdata;
    assign o_wr_stb  = r_wr_stb;
    assign o_rd_stb  = r_rd_stb;

`ifdef CMD_REG_BANK_ERR_EN
    // ------------------------------------------------------------------
    // Bad-address reporting
    // ------------------------------------------------------------------
    logic        r_bad_addr;
    logic [15:0] r_bad_addr_cnt;
    logic        w_miss;

    assign w_miss = cmd.sel && !w_hit;

    // Pulse once per missed transaction and count misses, saturating at all-ones.
    always_ff @(posedge i_sysclk) begin
        if (!i_srst_n) begin
            r_bad_addr     <= 1'b0;
            r_bad_addr_cnt <= '0;
        end else begin
            r_bad_addr <= w_miss;
            if (w_miss && (r_bad_addr_cnt != 16'hFFFF)) begin
                r_bad_addr_cnt <= r_bad_addr_cnt + 16'd1;
            end
        end
    end

    assign o_bad_addr     = r_bad_addr;
    assign o_bad_addr_cnt = r_bad_addr_cnt;
`endif

endmodule

// File: tb/tb_cmd_reg_bank.sv
// Self-checking bench for cmd_reg_bank: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the register bank.
module tb_cmd_reg_bank;

    localparam int unsigned     DW   = 32;
    localparam int unsigned     NR   = 4;
    localparam int unsigned     Base = 0;
    localparam logic [NR-1:0]   RoMask  = 4'b0100;
    localparam logic [NR-1:0]   W1cMask = 4'b1000;
    localparam logic [NR*DW-1:0] RstVals =
        {32'h0000_0000, 32'hDEAD_0000, 32'h0000_1234, 32'h0000_00AA};
`ifdef CMD_REG_BANK_ERR_EN
    localparam logic [DW-1:0]   MissVal = 32'hDEAD_BEEF;
`else
    localparam logic [DW-1:0]   MissVal = 32'h0;
`endif

    logic              clk = 1'b0;
    logic              srst_n;
    logic [NR*DW-1:0]  hw_val;
    logic [NR*DW-1:0]  hw_set;
    logic [NR*DW-1:0]  regs;
    logic [NR-1:0]     wr_stb;
    logic [NR-1:0]     rd_stb;
`ifdef CMD_REG_BANK_ERR_EN
    logic              bad_addr;
    logic [15:0]       bad_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [NR-1:0]  ro_m;
    logic [NR-1:0]  w1c_m;
    logic [NR*DW-1:0] rst_m;
    logic [DW-1:0]  m_reg [NR];
    logic [DW-1:0]  m_rdata;
    logic           m_ack;
    logic [NR-1:0]  m_wr_stb;
    logic [NR-1:0]  m_rd_stb;
    logic           m_bad;
    int             m_bad_cnt;

    intf_cmd #(.DATA_BITS(DW), .ADDR_BITS(32)) cmd_if ();

    cmd_reg_bank #(
        .DATA_BITS (DW),
        .NUM_REGS  (NR),
        .ADDR_BITS (32),
        .BASE_ADDR (Base),
        .RO_MASK   (RoMask),
        .W1C_MASK  (W1cMask),
        .RST_VALS  (RstVals)
    ) dut (
        .i_sysclk (clk),
        .i_srst_n (srst_n),
        .cmd      (cmd_if),
        .i_hw_val (hw_val),
        .i_hw_set (hw_set),
        .o_regs   (regs),
        .o_wr_stb (wr_stb),
        .o_rd_stb (rd_stb)
`ifdef CMD_REG_BANK_ERR_EN
        ,
        .o_bad_addr     (bad_addr),
        .o_bad_addr_cnt (bad_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [NR*DW-1:0] act,
                            input logic [NR*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] exp_regs();
        logic [NR*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) begin
            if (!ro_m[i]) v[i*DW +: DW] = m_reg[i];
        end
        return v;
    endfunction

    // Apply the bank's rules to the inputs presented for the coming clock edge.
    task automatic model_step();
        longint        off;
        logic          hit;
        int            idx;
        logic [DW-1:0] nxt [NR];
        logic [DW-1:0] clr;
        logic          is_wr;
        logic          is_rd;
        off   = longint'(cmd_if.byte_addr) - longint'(Base);
        hit   = (off >= 0) && (off % 4 == 0) && (off / 4 < NR);
        idx   = hit ? int'(off / 4) : 0;
        is_wr = cmd_if.sel && !cmd_if.rd_wr_n;
        is_rd = cmd_if.sel && cmd_if.rd_wr_n;
        if (!srst_n) begin
            for (int i = 0; i < NR; i++) m_reg[i] = rst_m[i*DW +: DW];
            m_ack = 0; m_rdata = '0; m_wr_stb = '0; m_rd_stb = '0;
            m_bad = 0; m_bad_cnt = 0;
        end else begin
            m_ack    = cmd_if.sel;
            m_wr_stb = '0;
            m_rd_stb = '0;
            m_bad    = cmd_if.sel && !hit;
            if (m_bad && m_bad_cnt < 65535) m_bad_cnt++;
            for (int i = 0; i < NR; i++) begin
                nxt[i] = m_reg[i];
                if (w1c_m[i]) begin
                    clr    = (is_wr && hit && idx == i) ? cmd_if.wdata : '0;
                    nxt[i] = (m_reg[i] & ~clr) | hw_set[i*DW +: DW];
                end
            end
            if (is_wr && hit && !ro_m[idx]) begin
                if (!w1c_m[idx]) nxt[idx] = cmd_if.wdata;
                m_wr_stb[idx] = 1'b1;
            end
            if (is_rd) begin
                if (hit) begin
                    m_rd_stb[idx] = 1'b1;
                    m_rdata = ro_m[idx] ? hw_val[idx*DW +: DW] : m_reg[idx];
                end else begin
                    m_rdata = MissVal;
                end
            end
            for (int i = 0; i < NR; i++) m_reg[i] = nxt[i];
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_eq("ack", cmd_if.ack, m_ack);
        check_eq("wr_stb", wr_stb, m_wr_stb);
        check_eq("rd_stb", rd_stb, m_rd_stb);
        check_eq("rdata", cmd_if.rdata, m_rdata);
        check_eq("regs", regs, exp_regs());
`ifdef CMD_REG_BANK_ERR_EN
        check_eq("bad_addr", bad_addr, m_bad);
        check_eq("bad_cnt", bad_cnt, m_bad_cnt);
`endif
    endtask

    task automatic drive(input logic sel, input logic rd, input logic [31:0] addr,
                         input logic [DW-1:0] wdata);
        cmd_if.sel       = sel;
        cmd_if.rd_wr_n   = rd;
        cmd_if.byte_addr = addr;
        cmd_if.wdata     = wdata;
    endtask

    initial begin
        logic [31:0] addr;
        ro_m  = RoMask;
        w1c_m = W1cMask;
        rst_m = RstVals;
        srst_n = 1'b0;
        hw_val = '0;
        hw_set = '0;
        drive(0, 1, 32'h0, '0);

        // Reset defaults
        step();
        step();
        check_eq("rst_regs", regs, {32'h0, 32'h0, 32'h1234, 32'hAA});
        check_eq("rst_ack", cmd_if.ack, 1'b0);
        srst_n = 1'b1;
        drive(1, 1, 32'h4, '0);
        step();
        check_eq("rst_rd_ack", cmd_if.ack, 1'b1);
        check_eq("rst_rd_data", cmd_if.rdata, 32'h1234);
        check_eq("rst_rd_stb", rd_stb, 4'b0010);
        drive(0, 1, 32'h0, '0);
        step();
        check_eq("idle_ack", cmd_if.ack, 1'b0);

        // RW write and back-to-back readback
        hw_val[2*DW +: DW] = 32'hCAFE;
        drive(1, 0, 32'h0, 32'hA5A5_0001);
        step();
        check_eq("rw_wr_stb", wr_stb, 4'b0001);
        check_eq("rw_reg0", regs[31:0], 32'hA5A5_0001);
        drive(1, 1, 32'h0, '0); step();
        check_eq("b2b_rd0", cmd_if.rdata, 32'hA5A5_0001);
        drive(1, 1, 32'h4, '0); step();
        check_eq("b2b_rd1", cmd_if.rdata, 32'h1234);
        drive(1, 1, 32'h8, '0); step();
        check_eq("b2b_rd2", cmd_if.rdata, 32'hCAFE);
        drive(1, 1, 32'hC, '0); step();
        check_eq("b2b_rd3", cmd_if.rdata, 32'h0);
        check_eq("b2b_ack", cmd_if.ack, 1'b1);

        // RO register ignores writes
        drive(1, 0, 32'h8, 32'hFFFF); step();
        check_eq("ro_wr_ack", cmd_if.ack, 1'b1);
        check_eq("ro_wr_stb", wr_stb, 4'b0000);
        drive(1, 1, 32'h8, '0); step();
        check_eq("ro_rd", cmd_if.rdata, 32'hCAFE);

        // W1C clear racing a hardware set
        drive(0, 1, 32'h0, '0);
        hw_set[3*DW +: DW] = 32'h5; step();
        check_eq("w1c_set", regs[3*DW +: DW], 32'h5);
        drive(1, 0, 32'hC, 32'h5);
        hw_set[3*DW +: DW] = 32'h4; step();
        check_eq("w1c_race", regs[3*DW +: DW], 32'h4);
        check_eq("w1c_wr_stb", wr_stb, 4'b1000);
        hw_set = '0;
        drive(1, 1, 32'hC, '0); step();
        check_eq("w1c_rd", cmd_if.rdata, 32'h4);

        // Misaligned and out-of-range reads
        drive(1, 1, 32'h2, '0); step();
        check_eq("miss_unaligned", cmd_if.rdata, MissVal);
        check_eq("miss_unaligned_stb", rd_stb, 4'b0000);
        drive(1, 1, 32'h10, '0); step();
        check_eq("miss_range", cmd_if.rdata, MissVal);
        check_eq("miss_range_ack", cmd_if.ack, 1'b1);
`ifdef CMD_REG_BANK_ERR_EN
        check_eq("miss_bad_cnt", bad_cnt, 16'd2);
`endif

        // Reset in the same cycle as a write
        srst_n = 1'b0;
        drive(1, 0, 32'h0, 32'h77); step();
        check_eq("rst_mid_ack", cmd_if.ack, 1'b0);
        check_eq("rst_mid_reg0", regs[31:0], 32'hAA);
        srst_n = 1'b1;
        drive(0, 1, 32'h0, '0); step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            srst_n = ($urandom_range(0, 49) != 0);
            case ($urandom_range(0, 7))
                0, 1, 2, 3: addr = 32'($urandom_range(0, 3) * 4);
                4:          addr = 32'h2;
                5:          addr = 32'h10;
                6:          addr = $urandom;
                default:    addr = 32'($urandom_range(0, 3) * 4 + 1);
            endcase
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), addr, $urandom);
            for (int i = 0; i < NR; i++) hw_val[i*DW +: DW] = $urandom;
            hw_set = '0;
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < NR; i++) hw_set[i*DW +: DW] = $urandom & $urandom & $urandom;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
